// File: rtl/note_sched.sv
// Note sequencer sharing the tone generator between keypad notes and a built-in song,
// echoing every sounded note byte to the UART. Define SONG_LOOP_EN to loop the song endlessly.
module note_sched #(
  parameter int unsigned CLK_HZ         = 50000000,
  parameter int unsigned TICK_MS        = 125,
  parameter int unsigned KEY_HOLD_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  input  logic       play,
  input  logic       stop,
  input  logic       tx_done,
  output logic [7:0] note,
  output logic       playing,
  output logic       tx_en,
  output logic [7:0] tx_data,
  output logic       tx_drop
);
  localparam int unsigned TICK_CYC = CLK_HZ / 1000 * TICK_MS;
  localparam int unsigned PW       = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int unsigned DUR_MAX  = (KEY_HOLD_TICKS > 15) ? KEY_HOLD_TICKS : 15;
  localparam int unsigned TW       = $clog2(DUR_MAX + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYC - 1);
  localparam logic [TW-1:0] KEY_DUR    = TW'(KEY_HOLD_TICKS);

  typedef enum logic [1:0] {IDLE, SONG, KEY} state_e;
  typedef enum logic {TXI, TXW} tx_state_e;

  // Entry format {note[7:0], dur[3:0]}; dur 0 marks the end of the song.
  function automatic logic [11:0] song_rom(input logic [3:0] i);
    case (i)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: song_rom = {8'h31 + {4'h0, i}, 4'd2};
      4'd7:    song_rom = {8'h00, 4'd2};
      default: song_rom = 12'h000;
    endcase
  endfunction

  state_e          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic            playing_q, playing_d;
  logic [7:0]      note_q, note_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [TW-1:0]   tick_q, tick_d;

  logic [11:0]     cur_entry, next_entry, entry0, resume_entry;
  logic [3:0]      next_idx;
  logic [TW-1:0]   cur_dur;
  logic            expire;
  logic            start;
  logic [7:0]      start_note;
  logic            push;

  tx_state_e       tx_state_q, tx_state_d;
  logic [7:0]      mem_q [4];
  logic [7:0]      mem_d [4];
  logic [1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]      count_q, count_d;
  logic            tx_en_q, tx_en_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_drop_q, tx_drop_d;
  logic            pop, accept, full;

  assign cur_entry  = song_rom(idx_q);
  assign next_idx   = idx_q + 4'd1;
  assign next_entry = song_rom(next_idx);
  assign entry0     = song_rom(4'd0);
  assign cur_dur    = (state_q == KEY) ? KEY_DUR : TW'(cur_entry[3:0]);
  assign expire     = (state_q != IDLE) && (presc_q == PRESC_LAST) && (tick_q == cur_dur - TW'(1));

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    playing_d    = playing_q;
    note_d       = note_q;
    presc_d      = presc_q;
    tick_d       = tick_q;
    start        = 1'b0;
    start_note   = '0;
    resume_entry = '0;
    if (state_q != IDLE) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        tick_d  = tick_q + TW'(1);
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
    if (stop) begin
      state_d   = IDLE;
      idx_d     = '0;
      playing_d = 1'b0;
      note_d    = '0;
      presc_d   = '0;
      tick_d    = '0;
    end else if (key_valid) begin
      state_d    = KEY;
      start      = 1'b1;
      start_note = key_code;
    end else begin
      // play under a key only rewinds the song; the key keeps sounding until it expires
      if (play) begin
        playing_d = 1'b1;
        idx_d     = '0;
      end
      if (play && state_q != KEY) begin
        state_d    = SONG;
        start      = 1'b1;
        start_note = entry0[11:4];
      end else if (expire && state_q == SONG) begin
        if (next_entry[3:0] != 4'd0) begin
          idx_d      = next_idx;
          start      = 1'b1;
          start_note = next_entry[11:4];
        end else begin
`ifdef SONG_LOOP_EN
          idx_d      = '0;
          start      = 1'b1;
          start_note = entry0[11:4];
`else
          state_d   = IDLE;
          idx_d     = '0;
          playing_d = 1'b0;
          note_d    = '0;
          presc_d   = '0;
          tick_d    = '0;
`endif
        end
      end else if (expire && state_q == KEY) begin
        if (playing_d) begin
          state_d      = SONG;
          resume_entry = song_rom(idx_d);
          start        = 1'b1;
          start_note   = resume_entry[11:4];
        end else begin
          state_d = IDLE;
          note_d  = '0;
          presc_d = '0;
          tick_d  = '0;
        end
      end
    end
    if (start) begin
      note_d  = start_note;
      presc_d = '0;
      tick_d  = '0;
    end
  end

  assign push = start && (start_note != 8'h00);

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    tx_state_d = tx_state_q;
    tx_en_d    = 1'b0;
    tx_data_d  = tx_data_q;
    tx_drop_d  = 1'b0;
    full       = (count_q == 3'd4);
    pop        = (tx_state_q == TXI) && (count_q != 3'd0);
    accept     = 1'b0;
    if (tx_state_q == TXI) begin
      if (pop) begin
        tx_data_d  = mem_q[rd_ptr_q];
        tx_en_d    = 1'b1;
        rd_ptr_d   = rd_ptr_q + 2'd1;
        tx_state_d = TXW;
      end
    end else if (tx_done) begin
      tx_state_d = TXI;
    end
    // a pop in the same cycle frees the slot, so a full queue still accepts
    if (push) begin
      if (!full || pop) begin
        accept          = 1'b1;
        mem_d[wr_ptr_q] = start_note;
        wr_ptr_d        = wr_ptr_q + 2'd1;
      end else begin
        tx_drop_d = 1'b1;
      end
    end
    count_d = count_q + {2'b00, accept} - {2'b00, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      playing_q  <= 1'b0;
      note_q     <= '0;
      presc_q    <= '0;
      tick_q     <= '0;
      tx_state_q <= TXI;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_en_q    <= 1'b0;
      tx_data_q  <= '0;
      tx_drop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      playing_q  <= playing_d;
      note_q     <= note_d;
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      tx_state_q <= tx_state_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_en_q    <= tx_en_d;
      tx_data_q  <= tx_data_d;
      tx_drop_q  <= tx_drop_d;
    end
  end

  assign note    = note_q;
  assign playing = playing_q;
  assign tx_en   = tx_en_q;
  assign tx_data = tx_data_q;
  assign tx_drop = tx_drop_q;
endmodule

// File: tb/tb_note_sched.sv
// Bench for note_sched: directed scenarios plus random traffic against a cycle-count reference model.
module tb_note_sched;
  localparam int T        = 4;
  localparam int HOLD     = 2;
  localparam int SONG_LEN = 8;
  localparam int SONG_DUR = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_valid = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic       play = 1'b0;
  logic       stop = 1'b0;
  logic       man_done = 1'b0;
  logic       auto_pulse = 1'b0;
  logic       tx_done;
  logic [7:0] note, tx_data;
  logic       playing, tx_en, tx_drop;

  int checks = 0;
  int errors = 0;

  assign tx_done = auto_pulse | man_done;
  always #5 clk = ~clk;

  note_sched #(.CLK_HZ(1000), .TICK_MS(4), .KEY_HOLD_TICKS(2)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .play(play), .stop(stop), .tx_done(tx_done), .note(note), .playing(playing),
    .tx_en(tx_en), .tx_data(tx_data), .tx_drop(tx_drop)
  );

  // Reference model: mode 0 idle, 1 song, 2 key; m_left counts cycles left on the current note
  int         m_mode = 0, m_idx = 0, m_left = 0;
  logic [7:0] m_note = 8'h00, m_txd = 8'h00;
  bit         m_playing = 0, m_busy = 0, m_txen = 0, m_drop = 0;
  logic [7:0] mq[$];

  function automatic logic [7:0] song_note(int i);
    return (i < 7) ? 8'(8'h31 + i) : 8'h00;
  endfunction

  always @(posedge clk) begin
    bit pushed, expire;
    if (rst) begin
      m_mode = 0; m_idx = 0; m_left = 0; m_note = 8'h00; m_playing = 0;
      m_busy = 0; m_txen = 0; m_txd = 8'h00; m_drop = 0;
      mq.delete();
    end else begin
      pushed = 0;
      expire = (m_mode != 0) && (m_left == 1);
      if (m_mode != 0) m_left--;
      if (stop) begin
        m_mode = 0; m_note = 8'h00; m_playing = 0; m_idx = 0; m_left = 0;
      end else if (key_valid) begin
        m_mode = 2; m_note = key_code; m_left = HOLD * T; pushed = 1;
      end else begin
        if (play) begin m_playing = 1; m_idx = 0; end
        if (play && m_mode != 2) begin
          m_mode = 1; m_note = song_note(0); m_left = SONG_DUR * T; pushed = 1;
        end else if (expire && m_mode == 1) begin
          if (m_idx + 1 < SONG_LEN) begin
            m_idx++; m_note = song_note(m_idx); m_left = SONG_DUR * T; pushed = 1;
          end else begin
`ifdef SONG_LOOP_EN
            m_idx = 0; m_note = song_note(0); m_left = SONG_DUR * T; pushed = 1;
`else
            m_mode = 0; m_note = 8'h00; m_playing = 0; m_idx = 0;
`endif
          end
        end else if (expire && m_mode == 2) begin
          if (m_playing) begin
            m_mode = 1; m_note = song_note(m_idx); m_left = SONG_DUR * T; pushed = 1;
          end else begin
            m_mode = 0; m_note = 8'h00;
          end
        end
      end
      m_txen = 0; m_drop = 0;
      if (!m_busy) begin
        if (mq.size() > 0) begin m_txd = mq.pop_front(); m_txen = 1; m_busy = 1; end
      end else if (tx_done) begin
        m_busy = 0;
      end
      if (pushed && m_note != 8'h00) begin
        if (mq.size() < 4) mq.push_back(m_note);
        else m_drop = 1;
      end
    end
  end

  // Automatic UART stand-in: answers each tx_en with tx_done after 1..4 cycles
  bit auto_done = 0;
  int pend = 0;
  always @(negedge clk) begin
    auto_pulse = 1'b0;
    if (pend != 0) begin
      pend--;
      if (pend == 0) auto_pulse = 1'b1;
    end else if (auto_done && tx_en === 1'b1) begin
      pend = $urandom_range(1, 4);
    end
  end

  logic [7:0] sent[$];
  int drops = 0;
  always @(negedge clk) begin
    if (tx_en === 1'b1) sent.push_back(tx_data);
    if (tx_drop === 1'b1) drops++;
  end

  function automatic logic [18:0] dut_vec();
    return {note, playing, tx_en, tx_data, tx_drop};
  endfunction
  function automatic logic [18:0] mdl_vec();
    return {m_note, m_playing, m_txen, m_txd, m_drop};
  endfunction

  task automatic cyc(input logic r, input logic kv, input logic [7:0] kc,
                     input logic pl, input logic st, input logic md);
    rst = r; key_valid = kv; key_code = kc; play = pl; stop = st; man_done = md;
    @(negedge clk);
    rst = 1'b0; key_valid = 1'b0; play = 1'b0; stop = 1'b0; man_done = 1'b0;
  endtask

  task automatic test_reset();
    cyc(1, 1, 8'h55, 1, 0, 0);
    cyc(1, 0, 8'h00, 0, 0, 0);
    if (dut_vec() !== 19'h0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", dut_vec()); end
    checks++;
    if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL reset_model got=%h exp=%h", dut_vec(), mdl_vec()); end
    checks++;
  endtask

  task automatic test_song();
    int base;
    logic [7:0] exp_note;
    auto_done = 1;
    base = sent.size();
    cyc(0, 0, 8'h00, 1, 0, 0);
    for (int k = 1; k <= 70; k++) begin
      exp_note = (k <= 56) ? 8'(8'h31 + (k - 1) / 8) : 8'h00;
      if (note !== exp_note || playing !== (k <= 64)) begin
        errors++; $display("FAIL song_timing k=%0d got note=%h playing=%b exp note=%h playing=%b", k, note, playing, exp_note, k <= 64);
      end
      checks++;
      if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL song_model k=%0d got=%h exp=%h", k, dut_vec(), mdl_vec()); end
      checks++;
      cyc(0, 0, 8'h00, 0, 0, 0);
    end
    repeat (20) cyc(0, 0, 8'h00, 0, 0, 0);
    if (sent.size() - base !== 7) begin errors++; $display("FAIL song_echo_count got=%0d exp=7", sent.size() - base); end
    checks++;
    for (int i = 0; i < 7 && base + i < sent.size(); i++) begin
      if (sent[base + i] !== 8'(8'h31 + i)) begin
        errors++; $display("FAIL song_echo_byte i=%0d got=%h exp=%h", i, sent[base + i], 8'(8'h31 + i));
      end
      checks++;
    end
  endtask

  task automatic test_key_preempt();
    int base;
    logic [7:0] exp_note;
    logic [7:0] exp_echo [6];
    exp_echo = '{8'h31, 8'h32, 8'h33, 8'h41, 8'h33, 8'h34};
    auto_done = 1;
    base = sent.size();
    cyc(0, 0, 8'h00, 1, 0, 0);
    repeat (17) begin
      if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL preempt_model got=%h exp=%h", dut_vec(), mdl_vec()); end
      checks++;
      cyc(0, 0, 8'h00, 0, 0, 0);
    end
    if (note !== 8'h33) begin errors++; $display("FAIL preempt_before got=%h exp=33", note); end
    checks++;
    cyc(0, 1, 8'h41, 0, 0, 0);
    for (int k = 1; k <= 17; k++) begin
      exp_note = (k <= 8) ? 8'h41 : (k <= 16) ? 8'h33 : 8'h34;
      if (note !== exp_note || playing !== 1'b1) begin
        errors++; $display("FAIL preempt_note k=%0d got=%h/%b exp=%h/1", k, note, playing, exp_note);
      end
      checks++;
      if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL preempt_model k=%0d got=%h exp=%h", k, dut_vec(), mdl_vec()); end
      checks++;
      cyc(0, 0, 8'h00, 0, 0, 0);
    end
    cyc(0, 0, 8'h00, 0, 1, 0);
    repeat (30) cyc(0, 0, 8'h00, 0, 0, 0);
    if (sent.size() - base !== 6) begin errors++; $display("FAIL preempt_echo_count got=%0d exp=6", sent.size() - base); end
    checks++;
    for (int i = 0; i < 6 && base + i < sent.size(); i++) begin
      if (sent[base + i] !== exp_echo[i]) begin
        errors++; $display("FAIL preempt_echo i=%0d got=%h exp=%h", i, sent[base + i], exp_echo[i]);
      end
      checks++;
    end
  endtask

  task automatic test_overflow();
    int base, d0;
    logic [7:0] kb [6];
    auto_done = 0;
    repeat (10) cyc(0, 0, 8'h00, 0, 0, 0);
    base = sent.size();
    d0 = drops;
    foreach (kb[i]) kb[i] = 8'($urandom_range(1, 255));
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, kb[i], 0, 0, 0);
      if (tx_drop !== (i == 5)) begin errors++; $display("FAIL overflow_drop key=%0d got=%b exp=%b", i, tx_drop, i == 5); end
      checks++;
      repeat (2) begin
        if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL overflow_model got=%h exp=%h", dut_vec(), mdl_vec()); end
        checks++;
        cyc(0, 0, 8'h00, 0, 0, 0);
      end
    end
    repeat (12) cyc(0, 0, 8'h00, 0, 0, 0);
    if (sent.size() - base !== 1) begin errors++; $display("FAIL overflow_one_tx got=%0d exp=1", sent.size() - base); end
    checks++;
    if (drops - d0 !== 1) begin errors++; $display("FAIL overflow_drop_count got=%0d exp=1", drops - d0); end
    checks++;
    repeat (5) begin
      cyc(0, 0, 8'h00, 0, 0, 1);
      repeat (4) begin
        if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL overflow_drain got=%h exp=%h", dut_vec(), mdl_vec()); end
        checks++;
        cyc(0, 0, 8'h00, 0, 0, 0);
      end
    end
    if (sent.size() - base !== 5) begin errors++; $display("FAIL overflow_sent_count got=%0d exp=5", sent.size() - base); end
    checks++;
    for (int i = 0; i < 5 && base + i < sent.size(); i++) begin
      if (sent[base + i] !== kb[i]) begin errors++; $display("FAIL overflow_order i=%0d got=%h exp=%h", i, sent[base + i], kb[i]); end
      checks++;
    end
  endtask

  task automatic test_priority();
    int base;
    auto_done = 1;
    base = sent.size();
    cyc(0, 0, 8'h00, 1, 0, 0);
    repeat (5) cyc(0, 0, 8'h00, 0, 0, 0);
    cyc(0, 1, 8'h77, 1, 1, 0);
    if (note !== 8'h00 || playing !== 1'b0) begin
      errors++; $display("FAIL priority_stop got note=%h playing=%b exp note=00 playing=0", note, playing);
    end
    checks++;
    if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL priority_model got=%h exp=%h", dut_vec(), mdl_vec()); end
    checks++;
    repeat (25) cyc(0, 0, 8'h00, 0, 0, 0);
    if (sent.size() - base !== 1) begin errors++; $display("FAIL priority_no_push got=%0d exp=1", sent.size() - base); end
    checks++;
  endtask

  task automatic test_reset_mid();
    int base;
    logic [7:0] kd;
    auto_done = 0;
    repeat (10) cyc(0, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 8'(8'h50 + i), 0, 0, 0);
      repeat (2) cyc(0, 0, 8'h00, 0, 0, 0);
    end
    cyc(1, 0, 8'h00, 0, 0, 0);
    if (dut_vec() !== 19'h0) begin errors++; $display("FAIL rstmid_outputs got=%h exp=0", dut_vec()); end
    checks++;
    base = sent.size();
    for (int i = 0; i < 20; i++) cyc(0, 0, 8'h00, 0, 0, (i % 7) == 3);
    if (sent.size() !== base) begin errors++; $display("FAIL rstmid_no_tx got=%0d exp=%0d", sent.size(), base); end
    checks++;
    kd = 8'($urandom_range(1, 255));
    cyc(0, 1, kd, 0, 0, 0);
    repeat (3) begin
      if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL rstmid_model got=%h exp=%h", dut_vec(), mdl_vec()); end
      checks++;
      cyc(0, 0, 8'h00, 0, 0, 0);
    end
    if (sent.size() !== base + 1 || sent[sent.size() - 1] !== kd) begin
      errors++; $display("FAIL rstmid_new_tx got n=%0d last=%h exp n=%0d last=%h", sent.size() - base, sent[sent.size() - 1], 1, kd);
    end
    checks++;
    cyc(0, 0, 8'h00, 0, 0, 1);
    repeat (12) cyc(0, 0, 8'h00, 0, 0, 0);
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 3000; i++) begin
      if ((i % 200) == 0) auto_done = ($urandom_range(0, 3) != 0);
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 39) == 0,
          ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255)),
          $urandom_range(0, 59) == 0, $urandom_range(0, 149) == 0, $urandom_range(0, 29) == 0);
      if (dut_vec() !== mdl_vec()) begin
        errors++; bad++;
        if (bad <= 10) $display("FAIL random_model cycle=%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
      end
      checks++;
    end
    auto_done = 1;
  endtask

`ifdef SONG_LOOP_EN
  task automatic test_loop();
    int pos;
    logic [7:0] exp_note;
    cyc(0, 0, 8'h00, 0, 1, 0);
    cyc(0, 0, 8'h00, 1, 0, 0);
    for (int k = 1; k <= 150; k++) begin
      pos = (k - 1) % 64;
      exp_note = (pos < 56) ? 8'(8'h31 + pos / 8) : 8'h00;
      if (note !== exp_note || playing !== 1'b1) begin
        errors++; $display("FAIL loop_note k=%0d got=%h/%b exp=%h/1", k, note, playing, exp_note);
      end
      checks++;
      cyc(0, 0, 8'h00, 0, 0, 0);
    end
    cyc(0, 0, 8'h00, 0, 1, 0);
    if (note !== 8'h00 || playing !== 1'b0) begin errors++; $display("FAIL loop_stop got=%h/%b exp=00/0", note, playing); end
    checks++;
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_song();
    test_key_preempt();
    test_overflow();
    test_priority();
    test_reset_mid();
    test_random();
`ifdef SONG_LOOP_EN
    test_loop();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
